// File: rtl/cnn_stream_pkg.sv
// Shared constants and state encoding for the CNN image streamer.
//   IMG_W/IMG_H/PIX_W : frame geometry and pixel width
//   RES_W             : width of one signed CNN score
//   NUM_CLASSES       : scores collected per frame
//   ADDR_W/CLS_W      : frame-buffer address and class-index widths
package cnn_stream_pkg;

   localparam int unsigned IMG_W       = 28;
   localparam int unsigned IMG_H       = 28;
   localparam int unsigned IMG_PIXELS  = IMG_W * IMG_H;
   localparam int unsigned PIX_W       = 8;
   localparam int unsigned RES_W       = 32;
   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned CLS_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_COLLECT = 2'd2,
      ST_REPORT  = 2'd3
   } state_t;

endpackage

// File: rtl/cnn_frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
//   clock        : write and read clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, data valid one cycle after raddr
module cnn_frame_ram
#(
   parameter int unsigned DEPTH  = 784,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned AW     = 10
) (
   input  logic              clock,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Synchronous read port
   always_ff @(posedge clock) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/cnn_image_streamer.sv
// Streams a stored 28x28 frame into the CNN as one contiguous burst, then
// collects the final class scores and reports the signed argmax.
//   clock/reset          : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: host frame-buffer write port (IDLE only)
//   start                : one-cycle pulse to begin streaming (IDLE only)
//   busy                 : high while streaming/collecting/reporting
//   Pixel_In/data_in_valid : pixel stream to the CNN
//   cnn_out/cnn_out_valid  : final scores from the CNN
//   result_valid/result_class/result_score : classification pulse and held result
//   timeout_err          : pulse when scores do not arrive in time
module cnn_image_streamer
   import cnn_stream_pkg::*;
#(
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              start,
   output logic              busy,
   output logic [PIX_W-1:0]  Pixel_In,
   output logic              data_in_valid,
   input  logic [RES_W-1:0]  cnn_out,
   input  logic              cnn_out_valid,
   output logic              result_valid,
   output logic [CLS_W-1:0]  result_class,
   output logic [RES_W-1:0]  result_score,
   output logic              timeout_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_t                   state;
   state_t                   next_state;
   logic [ADDR_W-1:0]        pix_cnt;
   logic [CLS_W-1:0]         cls_cnt;
   logic [TMO_W-1:0]         tmo_cnt;
   logic                     rd_pend;
   logic signed [RES_W-1:0]  best_score;
   logic [CLS_W-1:0]         best_idx;
   logic [PIX_W-1:0]         ram_rdata;

   logic                     rd_issue_c;
   logic [ADDR_W-1:0]        rd_addr_c;
   logic                     ram_we_c;
   logic                     score_take_c;
   logic                     last_score_c;
   logic                     tmo_hit_c;
   logic signed [RES_W-1:0]  best_score_nx;
   logic [CLS_W-1:0]         best_idx_nx;
   logic                     busy_d;
   logic [PIX_W-1:0]         pixel_d;
   logic                     div_d;
   logic                     result_valid_d;
   logic [CLS_W-1:0]         result_class_d;
   logic [RES_W-1:0]         result_score_d;
   logic                     timeout_d;

   // Score-phase events; the final score beats a coincident timeout
   assign score_take_c = (state == ST_COLLECT) && cnn_out_valid;
   assign last_score_c = score_take_c && (cls_cnt == CLS_W'(NUM_CLASSES - 1));
   assign tmo_hit_c    = (state == ST_COLLECT) && !last_score_c &&
                         (tmo_cnt == TMO_W'(TIMEOUT - 1));

   // Frame buffer
   cnn_frame_ram #(
      .DEPTH  (IMG_PIXELS),
      .DATA_W (PIX_W),
      .AW     (ADDR_W)
   ) u_ram (
      .clock  (clock),
      .we     (ram_we_c),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .raddr  (rd_addr_c),
      .rdata  (ram_rdata)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (start) next_state = ST_STREAM;
         end
         ST_STREAM: begin
            // Leave once the two-stage read pipeline has drained
            if (pix_cnt == ADDR_W'(IMG_PIXELS + 1)) next_state = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (last_score_c)   next_state = ST_REPORT;
            else if (tmo_hit_c) next_state = ST_IDLE;
         end
         ST_REPORT: begin
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath controls and next values of the registered outputs
   always_comb begin
      rd_issue_c     = 1'b0;
      rd_addr_c      = '0;
      ram_we_c       = 1'b0;
      best_score_nx  = best_score;
      best_idx_nx    = best_idx;
      busy_d         = 1'b0;
      pixel_d        = '0;
      div_d          = 1'b0;
      result_valid_d = 1'b0;
      result_class_d = result_class;
      result_score_d = result_score;
      timeout_d      = 1'b0;

      rd_issue_c = (state == ST_STREAM) && (pix_cnt < ADDR_W'(IMG_PIXELS));
      if (rd_issue_c) rd_addr_c = pix_cnt;
      ram_we_c = (state == ST_IDLE) && wr_en && (wr_addr < ADDR_W'(IMG_PIXELS));

      // Strictly-greater update keeps the lowest index on ties
      if (score_take_c &&
          ((cls_cnt == CLS_W'(0)) || ($signed(cnn_out) > best_score))) begin
         best_score_nx = $signed(cnn_out);
         best_idx_nx   = cls_cnt;
      end

      busy_d  = (next_state != ST_IDLE) || tmo_hit_c;
      div_d   = rd_pend;
      pixel_d = rd_pend ? ram_rdata : '0;

      if (last_score_c) begin
         result_valid_d = 1'b1;
         result_class_d = best_idx_nx;
         result_score_d = $unsigned(best_score_nx);
      end
      timeout_d = tmo_hit_c;
   end

   // Counters, read pipeline and argmax registers
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_cnt    <= '0;
         cls_cnt    <= '0;
         tmo_cnt    <= '0;
         rd_pend    <= 1'b0;
         best_score <= '0;
         best_idx   <= '0;
      end else begin
         pix_cnt <= (state == ST_STREAM) ? pix_cnt + ADDR_W'(1) : '0;
         if (state == ST_COLLECT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (score_take_c) cls_cnt <= cls_cnt + CLS_W'(1);
         end else begin
            tmo_cnt <= '0;
            cls_cnt <= '0;
         end
         rd_pend    <= rd_issue_c;
         best_score <= best_score_nx;
         best_idx   <= best_idx_nx;
      end
   end

   // Output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         busy          <= 1'b0;
         Pixel_In      <= '0;
         data_in_valid <= 1'b0;
         result_valid  <= 1'b0;
         result_class  <= '0;
         result_score  <= '0;
         timeout_err   <= 1'b0;
      end else begin
         busy          <= busy_d;
         Pixel_In      <= pixel_d;
         data_in_valid <= div_d;
         result_valid  <= result_valid_d;
         result_class  <= result_class_d;
         result_score  <= result_score_d;
         timeout_err   <= timeout_d;
      end
   end

endmodule

// File: tb/tb_cnn_image_streamer.sv
// Scoreboard bench for cnn_image_streamer: the driver pushes expected pixels
// and results into queues, independent monitors pop and compare them.
module tb_cnn_image_streamer;
   import cnn_stream_pkg::*;

   localparam int unsigned TMO = 50;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        start;
   logic        busy;
   logic [7:0]  Pixel_In;
   logic        data_in_valid;
   logic [31:0] cnn_out;
   logic        cnn_out_valid;
   logic        result_valid;
   logic [3:0]  result_class;
   logic [31:0] result_score;
   logic        timeout_err;

   always #5 clock = ~clock;

   cnn_image_streamer #(.TIMEOUT(TMO)) dut (
      .clock         (clock),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .busy          (busy),
      .Pixel_In      (Pixel_In),
      .data_in_valid (data_in_valid),
      .cnn_out       (cnn_out),
      .cnn_out_valid (cnn_out_valid),
      .result_valid  (result_valid),
      .result_class  (result_class),
      .result_score  (result_score),
      .timeout_err   (timeout_err)
   );

   typedef struct packed {
      logic        is_tmo;
      logic [3:0]  cls;
      logic [31:0] score;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] pix_q[$];
   res_t res_q[$];
   int   run_len = 0;
   bit   aborted = 1'b0;
   bit   prev_valid = 1'b0;
   int   sc[10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Pixel monitor: order, value and burst length of the stream
   always @(negedge clock) begin
      logic [7:0] e;
      if (data_in_valid) begin
         if (pix_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected got=0x%0h", Pixel_In);
         end else begin
            e = pix_q.pop_front();
            check("pixel", 32'(Pixel_In), 32'(e));
         end
         run_len++;
      end else if (prev_valid) begin
         if (!aborted) check("burst_len", run_len, IMG_PIXELS);
         check("pixel_after_burst", 32'(Pixel_In), 32'h0);
         run_len = 0;
      end
      prev_valid = data_in_valid;
   end

   // Result monitor: every result/timeout pulse must match the queue head
   always @(negedge clock) begin
      res_t e;
      if (result_valid || timeout_err) begin
         if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected rv=%0b to=%0b cls=%0d", result_valid, timeout_err, result_class);
         end else begin
            e = res_q.pop_front();
            check("timeout_kind", 32'(timeout_err), 32'(e.is_tmo));
            check("result_kind", 32'(result_valid), 32'(!e.is_tmo));
            if (!e.is_tmo) begin
               check("result_class", 32'(result_class), 32'(e.cls));
               check("result_score", result_score, e.score);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_frame();
      for (int i = 0; i < int'(IMG_PIXELS); i++) begin
         wr_en   = 1'b1;
         wr_addr = 10'(i);
         wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   // Pulse start (optionally with a same-cycle write to address 0)
   task automatic start_stream(input bit wr_too, input logic [7:0] d0);
      for (int i = 0; i < int'(IMG_PIXELS); i++)
         pix_q.push_back((i == 0 && wr_too) ? d0 : 8'(i));
      aborted = 1'b0;
      start = 1'b1;
      if (wr_too) begin
         wr_en   = 1'b1;
         wr_addr = 10'd0;
         wr_data = d0;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      check("start_busy", 32'(busy), 32'h1);
      check("lat_edge1", 32'(data_in_valid), 32'h0);
      tick();
      check("lat_edge2", 32'(data_in_valid), 32'h0);
      tick();
      check("lat_edge3", 32'(data_in_valid), 32'h1);
   endtask

   // Run until the burst ends (COLLECT entry); optionally poke start/wr mid-burst
   task automatic wait_collect(input int inject_at);
      int n;
      for (n = 0; n < 1000; n++) begin
         if (n == inject_at) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 10'd0;
            wr_data = 8'hAA;
         end
         tick();
         start = 1'b0;
         wr_en = 1'b0;
         if (!data_in_valid) break;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL burst_end_timeout got=%0d exp=<1000", n);
      end
   endtask

   task automatic send_scores(input int n, input int gap_a, input int gap_b);
      for (int i = 0; i < n; i++) begin
         cnn_out       = sc[i];
         cnn_out_valid = 1'b1;
         tick();
         cnn_out_valid = 1'b0;
         if (i == gap_a || i == gap_b) repeat (3) tick();
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      cnn_out = '0; cnn_out_valid = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_div", 32'(data_in_valid), 32'h0);
      check("rst_pixel", 32'(Pixel_In), 32'h0);
      check("rst_rv", 32'(result_valid), 32'h0);
      check("rst_class", 32'(result_class), 32'h0);
      check("rst_score", result_score, 32'h0);
      check("rst_to", 32'(timeout_err), 32'h0);
      reset = 1'b0;
      tick();

      load_frame();

      // Mixed scores with gaps; tie at index 4 keeps index 2
      start_stream(1'b0, 8'h00);
      wait_collect(-1);
      sc = '{-5, 3, 7, -1, 7, 2, 0, 1, 6, 4};
      res_q.push_back('{is_tmo: 1'b0, cls: 4'd2, score: 32'd7});
      send_scores(10, 2, 5);
      check("report_busy", 32'(busy), 32'h1);
      tick();
      check("idle_busy", 32'(busy), 32'h0);
      // Extra valids after the report are ignored
      send_scores(2, -1, -1);
      repeat (3) tick();
      check("hold_class", 32'(result_class), 32'h2);
      check("hold_score", result_score, 32'h7);

      // All-negative scores, with start/wr pulsed mid-stream
      start_stream(1'b0, 8'h00);
      wait_collect(100);
      sc = '{-100, -2, -50, -3, -7, -9, -20, -30, -2, -60};
      res_q.push_back('{is_tmo: 1'b0, cls: 4'd1, score: 32'hFFFF_FFFE});
      send_scores(10, -1, -1);
      repeat (2) tick();

      // Only nine scores: timeout 50 cycles after COLLECT entry (pixel 0 still original)
      start_stream(1'b0, 8'h00);
      wait_collect(-1);
      res_q.push_back('{is_tmo: 1'b1, cls: 4'd0, score: 32'd0});
      send_scores(9, -1, -1);
      cnt = 9;
      while (!timeout_err && cnt < 200) begin
         tick();
         cnt++;
      end
      check("timeout_latency", cnt, TMO);
      check("timeout_busy", 32'(busy), 32'h1);
      tick();
      check("post_timeout_busy", 32'(busy), 32'h0);
      check("post_timeout_pulse", 32'(timeout_err), 32'h0);
      repeat (2) tick();

      // Reset in the middle of a burst
      start_stream(1'b0, 8'h00);
      repeat (400) tick();
      aborted = 1'b1;
      reset = 1'b1;
      tick();
      check("midrst_div", 32'(data_in_valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      pix_q.delete();
      repeat (2) tick();

      // Full restream after reset; signed extremes
      start_stream(1'b0, 8'h00);
      wait_collect(-1);
      sc = '{32'h8000_0000, -1, 0, 1, 2, 3, 4, 5, 6, 32'h7FFF_FFFF};
      res_q.push_back('{is_tmo: 1'b0, cls: 4'd9, score: 32'h7FFF_FFFF});
      send_scores(10, -1, -1);
      repeat (2) tick();

      // Write with start lands first; last score on the timeout cycle wins
      start_stream(1'b1, 8'hAA);
      wait_collect(-1);
      sc = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
      res_q.push_back('{is_tmo: 1'b0, cls: 4'd0, score: 32'd5});
      send_scores(9, -1, -1);
      repeat (40) tick();
      cnn_out       = 32'd5;
      cnn_out_valid = 1'b1;
      tick();
      cnn_out_valid = 1'b0;
      check("boundary_rv", 32'(result_valid), 32'h1);
      repeat (3) tick();

      check("pix_q_empty", pix_q.size(), 32'h0);
      check("res_q_empty", res_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
